ram_burst_initiator: RTL

CPU-side initiator for the 16x1024 single-port data RAM. Accepts load/store requests over a valid/ready handshake, drives the RAM's read/write enables, address and write data, and returns read data on a backpressured response channel. Reads may be bursts of 1–16 consecutive words. Writes are single-beat and posted. It sits between the CPU load/store stage and the RAM, which registers read data one clock after `read_en` and holds `dout` while `read_en` is low.

---
 rtl/ram_burst_initiator_pkg.sv | 16 +
 rtl/ram_burst_initiator_if.sv | 35 +++
 rtl/ram_burst_initiator_resp_fifo2.sv | 52 +++++
 rtl/ram_burst_initiator.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ram_burst_initiator_pkg.sv
// Shared definitions for the RAM burst initiator, the data RAM and the CPU side.
package ram_burst_initiator_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;
  localparam int unsigned MAX_BURST = 1 << LEN_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

endpackage

// File: rtl/ram_burst_initiator_if.sv
// Request/response channel plus RAM port of the burst initiator.
interface ram_burst_initiator_if;
  import ram_burst_initiator_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              ram_read_en;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // Initiator view
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_data, rsp_last, ram_read_en, ram_write_en, ram_addr,
           ram_din
  );

  // CPU + RAM environment view
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_data, rsp_last, ram_read_en, ram_write_en, ram_addr,
           ram_din
  );

endinterface

// File: rtl/ram_burst_initiator_resp_fifo2.sv
// Two-entry response FIFO; simultaneous push and pop allowed at any occupancy.
module ram_burst_initiator_resp_fifo2
  import ram_burst_initiator_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

  // Storage, pointers and occupancy. When full, push+pop overwrites the slot being popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!i_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

endmodule

// File: rtl/ram_burst_initiator.sv
// CPU-side initiator for the 16x1024 data RAM: posted writes, 1-16 beat read bursts.
module ram_burst_initiator
  import ram_burst_initiator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  ram_burst_initiator_if.slave  bus
);

  localparam logic [LEN_W:0] OneBeat = (LEN_W + 1)'(1);

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_next;
  logic [DATA_W-1:0] r_wdata, w_wdata_next;
  logic [LEN_W:0]    r_beats_left, w_beats_next;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [DATA_W-1:0] r_din_hold;
  logic              r_inflight;
  logic              r_last_tag;

  logic              w_rd_en;
  logic              w_wr_en;
  logic              w_last_issue;
  logic              w_req_ready;
  logic              w_pop;
  logic [2:0]        w_occupancy;
  logic              w_credit_ok;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W:0]   w_fifo_data;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;

  assign w_pop       = !w_fifo_empty && bus.rsp_ready;
  // Words already owed to the FIFO after this cycle's pop; a new read needs a free slot.
  assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit_ok = (w_occupancy < 3'd2);

  // Next-state, request accept and RAM enable decode
  always_comb begin
    w_state_next    = r_state;
    w_cur_addr_next = r_cur_addr;
    w_wdata_next    = r_wdata;
    w_beats_next    = r_beats_left;
    w_rd_en         = 1'b0;
    w_wr_en         = 1'b0;
    w_last_issue    = 1'b0;
    w_req_ready     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_cur_addr_next = bus.req_addr;
          w_wdata_next    = bus.req_wdata;
          w_beats_next    = {1'b0, bus.req_len} + OneBeat;
          w_state_next    = bus.req_we ? StWrite : StRead;
        end
      end
      StWrite: begin
        w_wr_en      = 1'b1;
        w_state_next = StIdle;
      end
      StRead: begin
        if (w_credit_ok) begin
          w_rd_en         = 1'b1;
          w_cur_addr_next = r_cur_addr + 1'b1;
          w_beats_next    = r_beats_left - OneBeat;
          w_last_issue    = (r_beats_left == OneBeat);
          if (w_last_issue) begin
            w_state_next = StIdle;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign w_ram_addr       = (w_rd_en || w_wr_en) ? r_cur_addr : r_addr_hold;
  assign bus.req_ready    = w_req_ready;
  assign bus.ram_read_en  = w_rd_en;
  assign bus.ram_write_en = w_wr_en;
  assign bus.ram_addr     = w_ram_addr;
  assign bus.ram_din      = w_wr_en ? r_wdata : r_din_hold;

  // State, request latches, held RAM outputs and in-flight read tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_cur_addr   <= '0;
      r_wdata      <= '0;
      r_beats_left <= '0;
      r_addr_hold  <= '0;
      r_din_hold   <= '0;
      r_inflight   <= 1'b0;
      r_last_tag   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cur_addr   <= w_cur_addr_next;
      r_wdata      <= w_wdata_next;
      r_beats_left <= w_beats_next;
      r_inflight   <= w_rd_en;
      r_last_tag   <= w_last_issue;
      if (w_rd_en || w_wr_en) begin
        r_addr_hold <= w_ram_addr;
      end
      if (w_wr_en) begin
        r_din_hold <= r_wdata;
      end
    end
  end

  ram_burst_initiator_resp_fifo2 #(
    .WIDTH(DATA_W + 1)
  ) u_resp_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_inflight),
    .i_data ({r_last_tag, bus.ram_dout}),
    .i_pop  (w_pop),
    .o_data (w_fifo_data),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

  assign bus.rsp_valid = !w_fifo_empty;
  assign bus.rsp_data  = w_fifo_data[DATA_W-1:0];
  assign bus.rsp_last  = w_fifo_data[DATA_W];

endmodule
